// File: rtl/fetch_redirect_if.sv
// Fetch redirect bundle between the redirect sources / fetch stage and the
// fetch PC controller.
//   master : drives pc_ready and all redirect requests, observes pc/pc_valid,
//            fetch_kill and flush_kind.
//   slave  : the controller; receives requests, owns pc and the kill/flush outputs.
interface fetch_redirect_if;
  logic        pc_ready;
  logic        eret_valid;
  logic [31:0] epc;
  logic        exc_valid;
  logic [31:0] exc_entrance;
  logic        refetch_valid;
  logic [31:0] refetch_addr;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        ds_fetched;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        fetch_kill;
  logic [1:0]  flush_kind;

  modport master (
    output pc_ready, eret_valid, epc, exc_valid, exc_entrance,
           refetch_valid, refetch_addr, branch_valid, branch_target,
           ds_fetched, pred_valid, pred_target,
    input  pc, pc_valid, fetch_kill, flush_kind
  );

  modport slave (
    input  pc_ready, eret_valid, epc, exc_valid, exc_entrance,
           refetch_valid, refetch_addr, branch_valid, branch_target,
           ds_fetched, pred_valid, pred_target,
    output pc, pc_valid, fetch_kill, flush_kind
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner and redirect sequencer.
// Arbitrates eret > exc > refetch > branch > pred each cycle, holds the
// winner in a one-entry pending slot while fetch is stalled, and flags
// wrong-path responses to fetch.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_redirect_if.slave (pc_ready + redirect requests in;
//                pc, pc_valid registered out; fetch_kill, flush_kind
//                combinational from the incoming redirects)
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned STEP     = 4
) (
  input logic             clk,
  input logic             reset,
  fetch_redirect_if.slave bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 3;
  localparam int unsigned FW = 2;

  localparam logic [RW-1:0] RANK_PRED    = RW'(0);
  localparam logic [RW-1:0] RANK_BRANCH  = RW'(1);
  localparam logic [RW-1:0] RANK_REFETCH = RW'(2);
  localparam logic [RW-1:0] RANK_EXC     = RW'(3);
  localparam logic [RW-1:0] RANK_ERET    = RW'(4);

  localparam logic [FW-1:0] FLUSH_NONE = FW'(0);
  localparam logic [FW-1:0] FLUSH_PCI  = FW'(1);
  localparam logic [FW-1:0] FLUSH_PCM  = FW'(2);
  localparam logic [FW-1:0] FLUSH_PCW  = FW'(3);

  typedef enum logic {RUN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [RW-1:0]   pend_rank_q, pend_rank_d;
  logic [AW-1:0]   pend_target_q, pend_target_d;
  logic            pend_kill_q, pend_kill_d;

  logic            in_v;
  logic [RW-1:0]   in_rank;
  logic [AW-1:0]   in_target;
  logic            in_kill;
  logic [FW-1:0]   in_flush;

  logic            pend_v;
  logic            accept;
  logic            in_wins;
  logic            fetch_kill_c;

  // Fixed-priority pick of this cycle's incoming redirect.
  always_comb begin
    in_v      = 1'b0;
    in_rank   = RANK_PRED;
    in_target = '0;
    in_kill   = 1'b0;
    in_flush  = FLUSH_NONE;
    if (bus.eret_valid) begin
      in_v = 1'b1; in_rank = RANK_ERET; in_target = bus.epc;
      in_kill = 1'b1; in_flush = FLUSH_PCW;
    end else if (bus.exc_valid) begin
      in_v = 1'b1; in_rank = RANK_EXC; in_target = bus.exc_entrance;
      in_kill = 1'b1; in_flush = FLUSH_PCW;
    end else if (bus.refetch_valid) begin
      in_v = 1'b1; in_rank = RANK_REFETCH; in_target = bus.refetch_addr;
      in_kill = 1'b1; in_flush = FLUSH_PCM;
    end else if (bus.branch_valid) begin
      // Unfetched delay slot: current pc is the slot, deliver it unkilled.
      in_v = 1'b1; in_rank = RANK_BRANCH; in_target = bus.branch_target;
      in_kill = bus.ds_fetched; in_flush = FLUSH_PCM;
    end else if (bus.pred_valid) begin
      in_v = 1'b1; in_rank = RANK_PRED; in_target = bus.pred_target;
      in_kill = 1'b1; in_flush = FLUSH_PCI;
    end
  end

  assign pend_v = (state_q == HOLD);
  // pc is not a request until pc_valid rises, so nothing is accepted before.
  assign accept  = bus.pc_ready & pc_valid_q;
  // Incoming beats pending on equal rank; a lower rank loses to the slot.
  assign in_wins = in_v & (~pend_v | (in_rank >= pend_rank_q));

  // Next-state, next-PC and pending-slot update.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = 1'b1;
    pend_rank_d   = pend_rank_q;
    pend_target_d = pend_target_q;
    pend_kill_d   = pend_kill_q;
    fetch_kill_c  = 1'b0;

    case (state_q)
      RUN, HOLD: begin
        if (accept) begin
          state_d = RUN;
          if (in_wins) begin
            pc_d         = in_target;
            fetch_kill_c = in_kill;
          end else if (pend_v) begin
            pc_d         = pend_target_q;
            fetch_kill_c = pend_kill_q;
          end else begin
            pc_d = pc_q + AW'(STEP);
          end
        end else if (in_wins) begin
          state_d       = HOLD;
          pend_rank_d   = in_rank;
          pend_target_d = in_target;
          // An unkilled branch overwritten by a higher rank must now kill.
          pend_kill_d   = in_kill | (pend_v & (in_rank > pend_rank_q));
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      pend_rank_q   <= RANK_PRED;
      pend_target_q <= '0;
      pend_kill_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      pend_rank_q   <= pend_rank_d;
      pend_target_q <= pend_target_d;
      pend_kill_q   <= pend_kill_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.fetch_kill = reset ? 1'b0 : fetch_kill_c;
  assign bus.flush_kind = reset ? FLUSH_NONE : in_flush;

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Owns the fetch PC register and sequences every PC redirect into the fetch stage. Each cycle it arbitrates the redirect sources (eret, exception, I-cache refetch, branch resolution, issue-stage prediction) by fixed priority. If fetch cannot accept a new address, it holds the winning redirect in a one-entry pending slot. It also tells fetch whether the response for the current PC is wrong-path and must be killed. It sits between the exception/branch units and the I-cache request port, and replaces free-running next-PC logic.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: PC loaded on reset.
- `STEP`, default 4: sequential increment in bytes (one instruction per fetch).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `pc_ready` in 1: fetch accepts the current `pc` this cycle.
- `eret_valid` in 1, `epc` in 32: eret commit; target is `epc`.
- `exc_valid` in 1, `exc_entrance` in 32: exception or interrupt; target is the exception entrance.
- `refetch_valid` in 1, `refetch_addr` in 32: I-cache or cache-op refetch request.
- `branch_valid` in 1, `branch_target` in 32, `ds_fetched` in 1: branch mispredict resolved. `ds_fetched=1` means the delay slot has already been accepted by fetch.
- `pred_valid` in 1, `pred_target` in 32: issue-stage predicted-taken redirect.
- `pc` out 32: current fetch address.
- `pc_valid` out 1: `pc` is a request.
- `fetch_kill` out 1: the response for the `pc` accepted this cycle is wrong-path.
- `flush_kind` out 2: 0 = none, 1 = PCI, 2 = PCM, 3 = PCW. Downstream buffer flush scope.

## Operation
- **Priority:** eret > exc > refetch > branch > pred.
  - Rank: eret=4, exc=3, refetch=2, branch=1, pred=0.
  - Only the highest valid source is taken each cycle.
- **`flush_kind` per winner:** eret/exc → 3 (PCW); refetch/branch → 2 (PCM); pred → 1 (PCI). It is driven combinationally from the incoming winner only, not from the pending slot.
- **Kill flag of a redirect:** 1, except for a branch with `ds_fetched=0`, which gets kill = 0. In that case the current `pc` is the delay slot: it must be delivered, and then fetch goes directly to `branch_target`.
- **Pending slot fields:** `pend_v`, `pend_rank`, `pend_target`, `pend_kill`.
- **FSM, 2 states:**
  - RUN: `pend_v=0`.
  - HOLD: `pend_v=1`.
- **Next-PC selection on a cycle with `pc_ready=1`:**
  - Source is the incoming winner if present, else the pending entry, else `pc+STEP`.
  - If an incoming winner and a pending entry coexist, the one with the higher rank is used; equal rank uses the incoming one.
  - `pc` updates to the selected value.
  - `fetch_kill` = the selected redirect's kill flag (0 for the sequential case).
  - The pending slot clears, giving a transition to RUN.
- **Cycle with `pc_ready=0`:**
  - `pc` holds and `fetch_kill=0`.
  - An incoming winner is written to the slot if `pend_v=0` or its rank ≥ `pend_rank`. Otherwise it is dropped, since the pending older instruction supersedes it.
  - This gives RUN→HOLD, or HOLD→HOLD with the slot overwritten.
- **Kill merge on overwrite:** when a branch with kill = 0 is overwritten by a higher rank, the stored kill becomes 1.
- **Address arithmetic:** 32-bit wrap-around; `32'hffff_fffc + 4 = 0`. No alignment check; misaligned targets pass through for the fetch stage to raise AdEL.
- **`pc_valid`:** 0 during reset and in the first cycle after reset release, then 1 permanently.

## Timing
- Reset values: `pc=RESET_PC`, `pc_valid=0`, `fetch_kill=0`, `flush_kind=0`, `pend_v=0`, state RUN.
- Redirect at cycle t with `pc_ready=1`: `pc=target` at t+1; `fetch_kill=1` at t (combinational).
- Redirect at t with `pc_ready` first high at t+k: `pc=target` at t+k+1; `fetch_kill` at t+k.
- `flush_kind` is asserted only in the arrival cycle t, for one cycle per request cycle.
- `reset` asserted in HOLD: the slot is discarded and `pc=RESET_PC` on the next edge.
- The only combinational path is redirect inputs → `fetch_kill`/`flush_kind`. `pc` comes straight from a flop.

## Test plan
- **Reset and sequential run:** reset 2 cycles, `pc_ready=1` → `pc` reads bfc00000, bfc00004, bfc00008; `pc_valid` rises one cycle after release; `fetch_kill=0` throughout.
- **Simultaneous sources:** `exc_valid` (`exc_entrance=bfc00380`) together with `branch_valid` and `pred_valid`, `pc_ready=1` → next `pc=bfc00380`, `fetch_kill=1`, `flush_kind=3`.
- **Hold then upgrade:** `pc_ready=0` with pred target 80001000, then refetch target 80002000 two cycles later, then `pc_ready=1` → `pc=80002000`, `fetch_kill=1` at the ready cycle, `flush_kind` 1 then 2 in the arrival cycles.
- **Lower rank dropped:** pending exc with `pc_ready=0`, then branch arrives → on ready `pc=exc_entrance`; the branch target is never seen.
- **Delay slot:** `pc=80000010`, branch target 80000100 with `ds_fetched=0`, `pc_ready=1` → `fetch_kill=0`, next `pc=80000100`. The same with `ds_fetched=1` → `fetch_kill=1`.
- **Reset in HOLD and wrap-around:** reset while in HOLD → `pc=bfc00000` and the pending redirect is never applied. Separately, redirect to fffffffc and run sequentially → `pc` goes fffffffc then 00000000.
